// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, legality check and small FSM state types.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Round-robin pointer: which requester wins a tie
  typedef enum logic {
    FAV0 = 1'b0,
    FAV1 = 1'b1
  } rr_state_e;

  // Per-requester response slot occupancy
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // True when the code is one the ALU implements
  function automatic bit alu_code_legal(input logic [3:0] code);
    bit legal;
    legal = 1'b0;
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL,
      ALU_SRL, ALU_SUB, ALU_SRA, ALU_SLT, ALU_SLTU: legal = 1'b1;
      default:                                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer flips away from whoever was last granted.
module rr_arbiter2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rr_state_e state_q;

  // Grant: single requester wins outright, a tie goes to the favoured one
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) begin
        gnt = (state_q == FAV0) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // Pointer FSM: favour the other requester after a grant, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FAV0;
    end else if (gnt[0]) begin
      state_q <= FAV1;
    end else if (gnt[1]) begin
      state_q <= FAV0;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with 1-cycle registered responses.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [3:0]        r0_alu_control,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  output logic              r0_resp_valid,
  input  logic              r0_resp_ready,
  output logic [DATA_W-1:0] r0_resp_result,
  output logic              r0_resp_zero,
  output logic              r0_resp_illegal,

  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [3:0]        r1_alu_control,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  output logic              r1_resp_valid,
  input  logic              r1_resp_ready,
  output logic [DATA_W-1:0] r1_resp_result,
  output logic              r1_resp_zero,
  output logic              r1_resp_illegal,

  output logic [3:0]        alu_control_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,

  output logic [CNT_W-1:0]  r0_grant_count,
  output logic [CNT_W-1:0]  r1_grant_count
);

  logic [1:0]        req_valid;
  logic [1:0]        resp_ready;
  logic [1:0]        slot_full;
  logic [1:0]        eligible;
  logic [1:0]        gnt;

  logic [3:0]        sel_code;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              sel_legal;

  slot_state_e       slot_q    [2];
  logic [DATA_W-1:0] result_q  [2];
  logic [1:0]        zero_q;
  logic [1:0]        illegal_q;
  logic [CNT_W-1:0]  cnt_q     [2];

  assign req_valid  = {r1_req_valid, r0_req_valid};
  assign resp_ready = {r1_resp_ready, r0_resp_ready};
  assign slot_full  = {slot_q[1] == SLOT_FULL, slot_q[0] == SLOT_FULL};

  // A full slot being drained this cycle is as good as empty
  assign eligible = req_valid & (~slot_full | resp_ready);

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (eligible),
    .gnt (gnt)
  );

  assign r0_req_ready = gnt[0];
  assign r1_req_ready = gnt[1];

  // Operand mux toward the ALU; idle and unlisted codes drive ADD
  always_comb begin
    sel_code      = gnt[1] ? r1_alu_control : r0_alu_control;
    sel_a         = gnt[1] ? r1_a : r0_a;
    sel_b         = gnt[1] ? r1_b : r0_b;
    sel_legal     = alu_code_legal(sel_code);
    alu_control_o = ALU_ADD;
    alu_a_o       = '0;
    alu_b_o       = '0;
    if (gnt != 2'b00) begin
      alu_control_o = sel_legal ? sel_code : ALU_ADD;
      alu_a_o       = sel_a;
      alu_b_o       = sel_b;
    end
  end

  // Response slots and saturating grant counters; a new load beats a drain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        slot_q[n]   <= SLOT_EMPTY;
        result_q[n] <= '0;
        cnt_q[n]    <= '0;
      end
      zero_q    <= 2'b00;
      illegal_q <= 2'b00;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (gnt[n]) begin
          slot_q[n]    <= SLOT_FULL;
          result_q[n]  <= alu_result_i;
          zero_q[n]    <= alu_zero_i;
          illegal_q[n] <= ~sel_legal;
          if (cnt_q[n] != {CNT_W{1'b1}}) begin
            cnt_q[n] <= cnt_q[n] + CNT_W'(1);
          end
        end else if (slot_full[n] && resp_ready[n]) begin
          slot_q[n] <= SLOT_EMPTY;
        end
      end
    end
  end

  assign r0_resp_valid   = slot_full[0];
  assign r0_resp_result  = result_q[0];
  assign r0_resp_zero    = zero_q[0];
  assign r0_resp_illegal = illegal_q[0];
  assign r1_resp_valid   = slot_full[1];
  assign r1_resp_result  = result_q[1];
  assign r1_resp_zero    = zero_q[1];
  assign r1_resp_illegal = illegal_q[1];
  assign r0_grant_count  = cnt_q[0];
  assign r1_grant_count  = cnt_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised bench for alu_share_arbiter with a transaction-level reference model.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  vld, rrdy;
  logic [3:0]  code [2];
  logic [31:0] opa  [2];
  logic [31:0] opb  [2];

  // Main DUT (CNT_W = 16)
  logic [1:0]  o_rdy, o_rv, o_rz, o_ri;
  logic [31:0] o_res [2];
  logic [15:0] o_cnt [2];
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_zero;

  // Narrow-counter DUT (CNT_W = 2)
  logic [1:0]  s_rdy, s_rv, s_rz, s_ri;
  logic [31:0] s_res [2];
  logic [1:0]  s_cnt [2];
  logic [3:0]  s_ctl;
  logic [31:0] s_a, s_b, s_alu_res;
  logic        s_alu_zero;

  // Reference ALU behaviour
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0011: return x ^ y;
      4'b0100: return x << y[4:0];
      4'b0101: return x >> y[4:0];
      4'b0111: return 32'($signed(x) >>> y[4:0]);
      4'b1000: return {31'd0, $signed(x) < $signed(y)};
      4'b1001: return {31'd0, x < y};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic bit legal_f(input logic [3:0] c);
    return c <= 4'd9;
  endfunction

  assign alu_res    = alu_f(alu_ctl, alu_a, alu_b);
  assign alu_zero   = (alu_res == 32'd0);
  assign s_alu_res  = alu_f(s_ctl, s_a, s_b);
  assign s_alu_zero = (s_alu_res == 32'd0);

  alu_share_arbiter #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(vld[0]), .r0_req_ready(o_rdy[0]), .r0_alu_control(code[0]),
    .r0_a(opa[0]), .r0_b(opb[0]), .r0_resp_valid(o_rv[0]), .r0_resp_ready(rrdy[0]),
    .r0_resp_result(o_res[0]), .r0_resp_zero(o_rz[0]), .r0_resp_illegal(o_ri[0]),
    .r1_req_valid(vld[1]), .r1_req_ready(o_rdy[1]), .r1_alu_control(code[1]),
    .r1_a(opa[1]), .r1_b(opb[1]), .r1_resp_valid(o_rv[1]), .r1_resp_ready(rrdy[1]),
    .r1_resp_result(o_res[1]), .r1_resp_zero(o_rz[1]), .r1_resp_illegal(o_ri[1]),
    .alu_control_o(alu_ctl), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_res), .alu_zero_i(alu_zero),
    .r0_grant_count(o_cnt[0]), .r1_grant_count(o_cnt[1])
  );

  alu_share_arbiter #(.DATA_W(32), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .r0_req_valid(vld[0]), .r0_req_ready(s_rdy[0]), .r0_alu_control(code[0]),
    .r0_a(opa[0]), .r0_b(opb[0]), .r0_resp_valid(s_rv[0]), .r0_resp_ready(rrdy[0]),
    .r0_resp_result(s_res[0]), .r0_resp_zero(s_rz[0]), .r0_resp_illegal(s_ri[0]),
    .r1_req_valid(vld[1]), .r1_req_ready(s_rdy[1]), .r1_alu_control(code[1]),
    .r1_a(opa[1]), .r1_b(opb[1]), .r1_resp_valid(s_rv[1]), .r1_resp_ready(rrdy[1]),
    .r1_resp_result(s_res[1]), .r1_resp_zero(s_rz[1]), .r1_resp_illegal(s_ri[1]),
    .alu_control_o(s_ctl), .alu_a_o(s_a), .alu_b_o(s_b),
    .alu_result_i(s_alu_res), .alu_zero_i(s_alu_zero),
    .r0_grant_count(s_cnt[0]), .r1_grant_count(s_cnt[1])
  );

  int checks = 0;
  int errors = 0;

  // Model state: slot contents, grant totals, last granted requester
  logic [1:0]  m_vld;
  logic [31:0] m_res [2];
  logic [1:0]  m_zero, m_ill;
  int          m_cnt [2];
  int          m_last;
  logic [1:0]  hold;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int min_i(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  // One clock: compare every output against the model, then advance the model
  task automatic step();
    logic [1:0]  el;
    int          g;
    logic [3:0]  ec;
    logic [31:0] ea, eb;
    @(negedge clk);
    el = rst ? 2'b00 : (vld & (~m_vld | rrdy));
    if (el == 2'b11) g = (m_last == 0) ? 1 : 0;
    else if (el[0])  g = 0;
    else if (el[1])  g = 1;
    else             g = -1;
    ec = 4'b0010; ea = 32'd0; eb = 32'd0;
    if (g >= 0) begin
      ec = legal_f(code[g]) ? code[g] : 4'b0010;
      ea = opa[g];
      eb = opb[g];
    end
    chk("alu_control", 64'(alu_ctl), 64'(ec));
    chk("alu_a", 64'(alu_a), 64'(ea));
    chk("alu_b", 64'(alu_b), 64'(eb));
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("req_ready%0d", n), 64'(o_rdy[n]), 64'(g == n));
      chk($sformatf("s_req_ready%0d", n), 64'(s_rdy[n]), 64'(g == n));
      chk($sformatf("resp_valid%0d", n), 64'(o_rv[n]), 64'(m_vld[n]));
      chk($sformatf("s_resp_valid%0d", n), 64'(s_rv[n]), 64'(m_vld[n]));
      chk($sformatf("resp_result%0d", n), 64'(o_res[n]), 64'(m_res[n]));
      chk($sformatf("resp_zero%0d", n), 64'(o_rz[n]), 64'(m_zero[n]));
      chk($sformatf("resp_illegal%0d", n), 64'(o_ri[n]), 64'(m_ill[n]));
      chk($sformatf("grant_count%0d", n), 64'(o_cnt[n]), 64'(min_i(m_cnt[n], 65535)));
      chk($sformatf("s_grant_count%0d", n), 64'(s_cnt[n]), 64'(min_i(m_cnt[n], 3)));
    end
    @(posedge clk);
    if (rst) begin
      m_vld = 2'b00; m_zero = 2'b00; m_ill = 2'b00; m_last = 1;
      for (int n = 0; n < 2; n++) begin
        m_res[n] = 32'd0;
        m_cnt[n] = 0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (g == n) begin
          m_vld[n]  = 1'b1;
          m_res[n]  = alu_f(ec, ea, eb);
          m_zero[n] = (m_res[n] == 32'd0);
          m_ill[n]  = !legal_f(code[n]);
          m_cnt[n]++;
        end else if (m_vld[n] && rrdy[n]) begin
          m_vld[n] = 1'b0;
        end
      end
      if (g >= 0) m_last = g;
    end
    hold = vld & ~{g == 1, g == 0};
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    vld[n] = v; code[n] = c; opa[n] = x; opb[n] = y;
  endtask

  initial begin
    m_vld = 2'b00; m_zero = 2'b00; m_ill = 2'b00; m_last = 1; hold = 2'b00;
    m_res[0] = 32'd0; m_res[1] = 32'd0; m_cnt[0] = 0; m_cnt[1] = 0;
    rst = 1'b1; rrdy = 2'b11;
    set_req(0, 1'b1, 4'b0010, 32'd1, 32'd2);
    set_req(1, 1'b1, 4'b0010, 32'd3, 32'd4);

    // Reset with both requests pending
    #1;
    chk("lit_rst_ready0", 64'(o_rdy[0]), 64'd0);
    chk("lit_rst_ready1", 64'(o_rdy[1]), 64'd0);
    chk("lit_rst_alu_ctl", 64'(alu_ctl), 64'h2);
    step(); step();
    chk("lit_rst_rv0", 64'(o_rv[0]), 64'd0);
    chk("lit_rst_cnt0", 64'(o_cnt[0]), 64'd0);

    // Single ADD
    rst = 1'b0;
    set_req(0, 1'b1, 4'b0010, 32'd5, 32'd7);
    vld[1] = 1'b0;
    #1;
    chk("lit_add_ready0", 64'(o_rdy[0]), 64'd1);
    step();
    chk("lit_add_rv0", 64'(o_rv[0]), 64'd1);
    chk("lit_add_res", 64'(o_res[0]), 64'd12);
    chk("lit_add_zero", 64'(o_rz[0]), 64'd0);
    chk("lit_add_ill", 64'(o_ri[0]), 64'd0);
    chk("lit_add_cnt", 64'(o_cnt[0]), 64'd1);

    // Tie after reset: r0 first, then r1
    vld[0] = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 4'b0110, 32'd9, 32'd9);
    set_req(1, 1'b1, 4'b1000, 32'hFFFF_FFFF, 32'd1);
    #1;
    chk("lit_tie_ready0", 64'(o_rdy[0]), 64'd1);
    chk("lit_tie_ready1", 64'(o_rdy[1]), 64'd0);
    step();
    chk("lit_sub_res", 64'(o_res[0]), 64'd0);
    chk("lit_sub_zero", 64'(o_rz[0]), 64'd1);
    vld[0] = 1'b0;
    #1;
    chk("lit_tie2_ready1", 64'(o_rdy[1]), 64'd1);
    step();
    chk("lit_slt_res", 64'(o_res[1]), 64'd1);

    // r1 slot blocked while r0 streams; release lets r1 in
    rrdy[1] = 1'b0;
    set_req(1, 1'b1, 4'b0010, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1'b1, 4'b0011, $urandom, $urandom);
      #1;
      chk("lit_blk_ready1", 64'(o_rdy[1]), 64'd0);
      chk("lit_blk_ready0", 64'(o_rdy[0]), 64'd1);
      step();
    end
    rrdy[1] = 1'b1;
    #1;
    chk("lit_rel_ready1", 64'(o_rdy[1]), 64'd1);
    step();
    chk("lit_rel_res1", 64'(o_res[1]), 64'd3);

    // Unlisted code runs as ADD and flags illegal
    vld[1] = 1'b0;
    set_req(0, 1'b1, 4'b1111, 32'd3, 32'd4);
    #1;
    chk("lit_ill_ctl", 64'(alu_ctl), 64'h2);
    step();
    chk("lit_ill_res", 64'(o_res[0]), 64'd7);
    chk("lit_ill_flag", 64'(o_ri[0]), 64'd1);

    // Reset right after a grant, then saturate the narrow counter
    vld[0] = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("lit_rst2_rv0", 64'(o_rv[0]), 64'd0);
    chk("lit_rst2_cnt0", 64'(o_cnt[0]), 64'd0);
    set_req(0, 1'b1, 4'b0010, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("lit_sat_s_cnt0", 64'(s_cnt[0]), 64'd3);
    chk("lit_sat_cnt0", 64'(o_cnt[0]), 64'd5);

    // Random traffic with occasional reset; pending requests stay stable
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 200) == 0;
      for (int n = 0; n < 2; n++) begin
        if (!hold[n]) begin
          vld[n]  = ($urandom % 4) != 0;
          code[n] = (($urandom % 6) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom % 10);
          opa[n]  = $urandom;
          opb[n]  = (($urandom % 4) == 0) ? opa[n] : $urandom;
        end
        rrdy[n] = ($urandom % 3) != 0;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
